shared_delay_sched: RTL

//  Round-robin scheduler that shares one programmable delay counter among NUM_REQ requesters
//  (power-sequencing and reset-timing FSMs). It grants the counter to one requester at a time and

---
 rtl/shared_delay_sched.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/shared_delay_sched.sv
// Round-robin owner of one programmable delay counter shared by NUM_REQ sequencers.
// Define SDS_PRESCALE_EN to add the iTick port and count only on tick cycles.
module shared_delay_sched #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic                     iClk,
    input  logic                     iRst_n,
    input  logic [NUM_REQ-1:0]       iReq,
    input  logic [NUM_REQ*CNT_W-1:0] iDelay,
`ifdef SDS_PRESCALE_EN
    input  logic                     iTick,
`endif
    output logic [NUM_REQ-1:0]       oGnt,
    output logic [NUM_REQ-1:0]       oDone,
    output logic                     oBusy,
    output logic [CNT_W-1:0]         oCntr
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } stateT;

    stateT              stateReg, stateNext;
    logic [NUM_REQ-1:0] gntReg, gntNext;
    logic [NUM_REQ-1:0] doneReg, doneNext;
    logic               busyReg, busyNext;
    logic [CNT_W-1:0]   cntrReg, cntrNext;
    logic [CNT_W-1:0]   dlyReg, dlyNext;
    logic [IDX_W-1:0]   gIdxReg, gIdxNext;
    logic [IDX_W-1:0]   ptrReg, ptrNext;

    logic [CNT_W-1:0]   delayArr [NUM_REQ];
    logic [IDX_W-1:0]   candIdx  [NUM_REQ];
    logic [NUM_REQ-1:0] candHit;
    logic [IDX_W-1:0]   pickIdx;
    logic               pickValid;
    logic               reqLost;
    logic               cntEn;

`ifdef SDS_PRESCALE_EN
    assign cntEn = iTick;
`else
    assign cntEn = 1'b1;
`endif

    // Candidate gi is the (gi+1)-th index after the pointer, wrapping at NUM_REQ.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : genCand
        logic [IDX_W:0] candSum;
        assign delayArr[gi] = iDelay[gi*CNT_W +: CNT_W];
        assign candSum      = {1'b0, ptrReg} + (IDX_W+1)'(gi + 1);
        assign candIdx[gi]  = (candSum >= (IDX_W+1)'(NUM_REQ))
                            ? IDX_W'(candSum - (IDX_W+1)'(NUM_REQ))
                            : candSum[IDX_W-1:0];
        assign candHit[gi]  = iReq[candIdx[gi]];
    end

    always_comb begin
        pickIdx   = '0;
        pickValid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (candHit[k]) begin
                pickIdx   = candIdx[k];
                pickValid = 1'b1;
            end
        end
    end

    assign reqLost = ~iReq[gIdxReg];

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            stateReg <= IDLE;
            gntReg   <= '0;
            doneReg  <= '0;
            busyReg  <= 1'b0;
            cntrReg  <= '0;
            dlyReg   <= '0;
            gIdxReg  <= '0;
            ptrReg   <= IDX_W'(NUM_REQ - 1);
        end else begin
            stateReg <= stateNext;
            gntReg   <= gntNext;
            doneReg  <= doneNext;
            busyReg  <= busyNext;
            cntrReg  <= cntrNext;
            dlyReg   <= dlyNext;
            gIdxReg  <= gIdxNext;
            ptrReg   <= ptrNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (pickValid) stateNext = LOAD;
            LOAD:    stateNext = reqLost ? IDLE : COUNT;
            COUNT: begin
                if (reqLost)                stateNext = IDLE;
                else if (cntrReg == dlyReg) stateNext = DONE;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        gntNext  = gntReg;
        doneNext = '0;
        cntrNext = cntrReg;
        dlyNext  = dlyReg;
        gIdxNext = gIdxReg;
        ptrNext  = ptrReg;
        busyNext = (stateNext != IDLE);
        case (stateReg)
            IDLE: begin
                if (pickValid) begin
                    gIdxNext = pickIdx;
                    gntNext  = {{(NUM_REQ-1){1'b0}}, 1'b1} << pickIdx;
                end
            end
            LOAD, COUNT: begin
                // A dropped request abandons the count; the pointer still advances past it.
                if (reqLost) begin
                    gntNext  = '0;
                    cntrNext = '0;
                    ptrNext  = gIdxReg;
                end else if (stateReg == LOAD) begin
                    dlyNext  = delayArr[gIdxReg];
                    cntrNext = '0;
                end else if (cntrReg == dlyReg) begin
                    doneNext = gntReg;
                end else if (cntEn) begin
                    cntrNext = cntrReg + CNT_W'(1);
                end
            end
            DONE: begin
                gntNext = '0;
                ptrNext = gIdxReg;
            end
            default: ;
        endcase
    end

    assign oGnt  = gntReg;
    assign oDone = doneReg;
    assign oBusy = busyReg;
    assign oCntr = cntrReg;

endmodule
